// File: rtl/fact_ctrl.sv
// Iterative factorial engine driven by a level-sensitive go/done handshake.
// Operands above MAX_N are rejected immediately with err set and result cleared.
module fact_ctrl #(
  parameter int N_W   = 4,
  parameter int W     = 32,
  parameter int MAX_N = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           go,
  input  logic [N_W-1:0] n,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [W-1:0]   result
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [N_W:0]   MAX_N_L = (N_W+1)'(MAX_N);
  localparam logic [N_W-1:0] CNT_ONE = N_W'(1);
  localparam logic [W-1:0]   PROD_ONE = W'(1);

  logic [1:0]     state;
  logic [N_W-1:0] cnt;
  logic [W-1:0]   prod;

  // Full-width product kept internally; only the low W bits are architecturally visible.
  function automatic logic [W-1:0] mul_trunc(input logic [W-1:0] a, input logic [N_W-1:0] b);
    logic [W+N_W-1:0] full;
    full = {{N_W{1'b0}}, a} * {{W{1'b0}}, b};
    return full[W-1:0];
  endfunction

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      err    <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            if ({1'b0, n} > MAX_N_L) begin
              err    <= 1'b1;
              result <= '0;
              state  <= DONE;
            end else begin
              cnt   <= n;
              prod  <= PROD_ONE;
              err   <= 1'b0;
              state <= RUN;
            end
          end
        end
        RUN: begin
          // cnt of 0 or 1 terminates immediately, so 0! and 1! both give 1
          if (cnt <= CNT_ONE) begin
            result <= prod;
            state  <= DONE;
          end else begin
            prod <= mul_trunc(prod, cnt);
            cnt  <= cnt - CNT_ONE;
          end
        end
        DONE: begin
          // go must drop before a new request is accepted
          if (!go) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fact_ctrl.sv
// Directed testbench for fact_ctrl: cycle-exact checks of the factorial handshake.
module tb_fact_ctrl;

  logic        clk;
  logic        rst;
  logic        go;
  logic [3:0]  n;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] result;

  int checks;
  int passed;

  fact_ctrl #(.N_W(4), .W(32), .MAX_N(12)) dut (
    .clk(clk), .rst(rst), .go(go), .n(n),
    .busy(busy), .done(done), .err(err), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge; returns on the following falling edge for sampling and driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; go = 1'b0; n = 4'd0;
    step(); step();
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else passed++;
    checks++; if (result !== 32'h0) $display("FAIL reset_result got %h want 00000000", result); else passed++;
    rst = 1'b1;
    step();
  endtask

  task automatic test_n5();
    n = 4'd5; go = 1'b1;
    step();  // edge k
    go = 1'b0;
    checks++; if (busy !== 1'b1) $display("FAIL n5_busy_k got %b want 1", busy); else passed++;
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL n5_run_k%0d busy=%b done=%b want busy=1 done=0", i, busy, done); else passed++;
      checks++; if (result !== 32'h0) $display("FAIL n5_hold_k%0d got %h want 00000000", i, result); else passed++;
    end
    step();  // k+5
    checks++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL n5_done done=%b busy=%b want done=1 busy=0", done, busy); else passed++;
    checks++; if (result !== 32'h00000078) $display("FAIL n5_result got %h want 00000078", result); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL n5_err got %b want 0", err); else passed++;
    step();
    checks++; if (done !== 1'b0) $display("FAIL n5_idle_done got %b want 0", done); else passed++;
  endtask

  task automatic test_n12();
    n = 4'd12; go = 1'b1;
    step();
    go = 1'b0;
    for (int i = 1; i <= 11; i++) step();
    checks++; if (done !== 1'b0 || busy !== 1'b1) $display("FAIL n12_k11 done=%b busy=%b want done=0 busy=1", done, busy); else passed++;
    step();
    checks++; if (done !== 1'b1) $display("FAIL n12_done got %b want 1", done); else passed++;
    checks++; if (result !== 32'h1C8CFC00) $display("FAIL n12_result got %h want 1c8cfc00", result); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL n12_err got %b want 0", err); else passed++;
    step();
  endtask

  task automatic test_n0_n1();
    n = 4'd0; go = 1'b1;
    step();
    go = 1'b0;
    checks++; if (busy !== 1'b1) $display("FAIL n0_busy got %b want 1", busy); else passed++;
    step();
    checks++; if (done !== 1'b1 || result !== 32'd1) $display("FAIL n0_done done=%b result=%h want done=1 result=00000001", done, result); else passed++;
    step();
    n = 4'd1; go = 1'b1;
    step();
    go = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL n1_busy busy=%b done=%b want busy=1 done=0", busy, done); else passed++;
    step();
    checks++; if (done !== 1'b1 || result !== 32'd1) $display("FAIL n1_done done=%b result=%h want done=1 result=00000001", done, result); else passed++;
    step();
  endtask

  task automatic test_err();
    n = 4'd5; go = 1'b1;
    step();
    go = 1'b0;
    for (int i = 1; i <= 5; i++) step();
    checks++; if (result !== 32'h78) $display("FAIL err_prior got %h want 00000078", result); else passed++;
    step();
    n = 4'd13; go = 1'b1;
    step();
    checks++; if (done !== 1'b1 || err !== 1'b1) $display("FAIL err_done done=%b err=%b want done=1 err=1", done, err); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL err_busy got %b want 0", busy); else passed++;
    checks++; if (result !== 32'h0) $display("FAIL err_result got %h want 00000000", result); else passed++;
    go = 1'b0;
    step();
    checks++; if (done !== 1'b0 || err !== 1'b1) $display("FAIL err_idle done=%b err=%b want done=0 err=1", done, err); else passed++;
    n = 4'd3; go = 1'b1;
    step();
    go = 1'b0;
    checks++; if (err !== 1'b0 || busy !== 1'b1) $display("FAIL err_clear err=%b busy=%b want err=0 busy=1", err, busy); else passed++;
    step(); step(); step();
    checks++; if (done !== 1'b1 || result !== 32'd6) $display("FAIL n3_result done=%b result=%h want done=1 result=00000006", done, result); else passed++;
    step();
  endtask

  task automatic test_hold();
    n = 4'd4; go = 1'b1;
    step();
    for (int i = 1; i <= 4; i++) step();
    checks++; if (done !== 1'b1 || result !== 32'h18) $display("FAIL hold_entry done=%b result=%h want done=1 result=00000018", done, result); else passed++;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (done !== 1'b1 || busy !== 1'b0 || result !== 32'h18) $display("FAIL hold_c%0d done=%b busy=%b result=%h want 1 0 00000018", i, done, busy, result); else passed++;
    end
    go = 1'b0;
    step();
    checks++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL hold_release done=%b busy=%b want 0 0", done, busy); else passed++;
  endtask

  task automatic test_reset_mid();
    n = 4'd10; go = 1'b1;
    step();
    go = 1'b0;
    step(); step(); step();
    checks++; if (busy !== 1'b1) $display("FAIL mid_busy got %b want 1", busy); else passed++;
    rst = 1'b0; go = 1'b1;
    step();  // k+4, reset wins over go
    rst = 1'b1; go = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || result !== 32'h0) $display("FAIL mid_reset busy=%b done=%b err=%b result=%h want all 0", busy, done, err, result); else passed++;
    step();
    checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL mid_idle busy=%b done=%b want 0 0", busy, done); else passed++;
    n = 4'd4; go = 1'b1;
    step();
    go = 1'b0;
    step(); step(); step();
    checks++; if (done !== 1'b0) $display("FAIL mid_n4_early got %b want 0", done); else passed++;
    step();
    checks++; if (done !== 1'b1 || result !== 32'h18) $display("FAIL mid_n4 done=%b result=%h want done=1 result=00000018", done, result); else passed++;
    step();
  endtask

  initial begin
    checks = 0;
    passed = 0;
    @(negedge clk);
    test_reset();
    test_n5();
    test_n12();
    test_n0_n1();
    test_err();
    test_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fact_ctrl.md
# fact_ctrl

Sequenced factorial engine for the FPGA system's general-purpose I/O path. It accepts an operand and a level-sensitive `go` from the processor's GPIO outputs, computes n! iteratively with an internal counter/product datapath under FSM control, and returns `result`, `done` and `err` for readback through GPIO inputs. It runs on the same processor clock domain as the rest of the system.

## Interface
Parameters:
- `N_W`, 4, width of operand `n`
- `W`, 32, width of product/result
- `MAX_N`, 12, largest operand whose factorial fits in `W` bits; larger operands raise `err`

Ports:
- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  reset, synchronous, active-low
- `go`  in  1  start request, level-sensitive
- `n`  in  N_W  operand, sampled only on the accepting edge
- `busy`  out  1  high while computing (state RUN)
- `done`  out  1  high in state DONE
- `err`  out  1  high in DONE when the accepted operand exceeded MAX_N
- `result`  out  W  last completed result

## Operation
- States: IDLE, RUN, DONE. Reset (`rst`=0 at an edge) forces IDLE from any state, including mid-RUN; the current computation is discarded.
- Internal registers: `cnt` (N_W bits), `prod` (W bits), `result` (W bits), `err` flag.
- IDLE: `busy`=0, `done`=0. On an edge with `go`=1:
  - if `n` > MAX_N: `err`<=1, `result`<=0, go to DONE.
  - else: `cnt`<=`n`, `prod`<=1, `err`<=0, go to RUN.
- RUN: on each edge:
  - if `cnt` <= 1: `result`<=`prod`, go to DONE.
  - else: `prod`<=`prod`*`cnt` (truncated to W bits; cannot overflow for n<=MAX_N), `cnt`<=`cnt`-1.
  - `go` is ignored in RUN; dropping it does not abort.
- DONE: `done`=1, `err` as latched. Stays until an edge with `go`=0, then returns to IDLE. `go` held high continuously does not restart; a new request requires `go` low then high (two-phase handshake).
- `result` changes only on entry to DONE (or reset); it holds the previous value during RUN and IDLE. `err` clears only on accepting a valid operand or on reset.
- n=0 and n=1 both yield result 1.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `result`=0, state IDLE.
- Let edge k be the IDLE edge that samples `go`=1.
- Valid operand: `busy`=1 after edge k; DONE entered and `done`=1 after edge k+max(n,1); `busy`=0 from the same edge. `result` valid in the same cycle `done` rises.
- Invalid operand (n>MAX_N): `done`=1 and `err`=1 after edge k; `busy` never asserts.
- Return to IDLE: one edge after `go` is sampled low in DONE; `done` falls after that edge. Earliest restart: the following edge with `go`=1.
- `go`=1 with `rst`=0 on the same edge: reset wins, state IDLE.

## Test plan
- Reset then `n`=5, `go`=1 at edge k → `busy`=1 for edges k..k+4, `done`=1 after k+5, `result`=0x00000078, `err`=0.
- `n`=12 → `done` after k+12, `result`=0x1C8CFC00 (479001600), `err`=0.
- `n`=0, then (after handshake) `n`=1 → each `done` after k+1, `result`=1.
- `n`=13 with prior `result`=0x78 → `done`=1 and `err`=1 after edge k, `result`=0, `busy` stays 0; then valid `n`=3 → `err`=0, `result`=6.
- Hold `go`=1 through DONE for 10 cycles → `done` stays 1, no restart, `result` stable; drop `go` → `done`=0 one edge later.
- `n`=10, assert `rst`=0 for one edge at k+4 → all outputs 0, state IDLE; subsequent `n`=4 → `result`=0x18.
